// File: rtl/laneswitch_ctrl.sv
// rtl/laneswitch_ctrl.sv - ping-pong ownership controller driving the laneswitch memory mux
// Hands the shared buffer between producer (lane 0) and consumer (lane 1) once it has gone quiet.
module laneswitch_ctrl #(
    parameter int QUIET_CYCLES = 2,
    parameter int TIMEOUT      = 1024,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 active,
    input  logic                 fault,
    input  logic                 lane0_done,
    input  logic                 lane1_done,
    input  logic                 clear_err,
    output logic                 switch,
    output logic                 lane0_grant,
    output logic                 lane1_grant,
    output logic                 draining,
    output logic [CNT_WIDTH-1:0] swap_count,
    output logic                 protocol_err,
    output logic                 timeout_err,
    output logic                 fault_err
);

    // quiet_cnt only ever holds 0..QUIET_CYCLES-1
    localparam int QW = (QUIET_CYCLES < 2) ? 1 : $clog2(QUIET_CYCLES);

    typedef enum logic [1:0] {OWN0, DRAIN0, OWN1, DRAIN1} state_t;

    state_t                state;
    logic [QW-1:0]         quiet_cnt;
    logic [CNT_WIDTH-1:0]  tmo_cnt;
    logic                  in_drain;
    logic                  quiet_done;
    logic                  tmo_hit;
    logic                  proto_set;

    always_comb begin
        in_drain   = (state == DRAIN0) || (state == DRAIN1);
        quiet_done = in_drain && !active && (quiet_cnt == QW'(QUIET_CYCLES - 1));
        tmo_hit    = (TIMEOUT != 0) && in_drain && (tmo_cnt == CNT_WIDTH'(TIMEOUT));
        proto_set  = 1'b0;
        case (state)
            OWN0:    proto_set = lane1_done;
            OWN1:    proto_set = lane0_done;
            default: proto_set = lane0_done | lane1_done;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= OWN0;
            switch       <= 1'b0;
            lane0_grant  <= 1'b1;
            lane1_grant  <= 1'b0;
            draining     <= 1'b0;
            quiet_cnt    <= '0;
            tmo_cnt      <= '0;
            swap_count   <= '0;
            protocol_err <= 1'b0;
            timeout_err  <= 1'b0;
            fault_err    <= 1'b0;
        end else begin
            // set beats clear when both happen in the same cycle
            protocol_err <= (protocol_err & ~clear_err) | proto_set;
            timeout_err  <= (timeout_err  & ~clear_err) | tmo_hit;
            fault_err    <= (fault_err    & ~clear_err) | fault;

            case (state)
                OWN0: if (lane0_done) begin
                    state       <= DRAIN0;
                    lane0_grant <= 1'b0;
                    draining    <= 1'b1;
                    quiet_cnt   <= '0;
                    tmo_cnt     <= '0;
                end
                OWN1: if (lane1_done) begin
                    state       <= DRAIN1;
                    lane1_grant <= 1'b0;
                    draining    <= 1'b1;
                    quiet_cnt   <= '0;
                    tmo_cnt     <= '0;
                end
                default: begin
                    if (quiet_done) begin
                        state       <= (state == DRAIN0) ? OWN1 : OWN0;
                        switch      <= (state == DRAIN0);
                        lane0_grant <= (state == DRAIN1);
                        lane1_grant <= (state == DRAIN0);
                        draining    <= 1'b0;
                        swap_count  <= swap_count + 1'b1;
                        quiet_cnt   <= '0;
                        tmo_cnt     <= '0;
                    end else begin
                        quiet_cnt <= active ? '0 : quiet_cnt + 1'b1;
                        if (tmo_cnt != '1)
                            tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    a_grant_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
        !(lane0_grant && lane1_grant));
    a_switch_on_drain_exit: assert property (@(posedge clk) disable iff (!reset_n)
        $changed(switch) |-> $past(draining));
    a_switch_when_quiet: assert property (@(posedge clk) disable iff (!reset_n)
        $changed(switch) |-> !$past(active));

endmodule

// File: tb/tb_laneswitch_ctrl.sv
// tb/tb_laneswitch_ctrl.sv - directed-vector bench for laneswitch_ctrl
module tb_laneswitch_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        active, fault, lane0_done, lane1_done, clear_err;
    logic        switch, lane0_grant, lane1_grant, draining;
    logic [15:0] swap_count;
    logic        protocol_err, timeout_err, fault_err;

    int vec_cnt = 0;
    int err_cnt = 0;

    laneswitch_ctrl #(.QUIET_CYCLES(2), .TIMEOUT(8), .CNT_WIDTH(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .active       (active),
        .fault        (fault),
        .lane0_done   (lane0_done),
        .lane1_done   (lane1_done),
        .clear_err    (clear_err),
        .switch       (switch),
        .lane0_grant  (lane0_grant),
        .lane1_grant  (lane1_grant),
        .draining     (draining),
        .swap_count   (swap_count),
        .protocol_err (protocol_err),
        .timeout_err  (timeout_err),
        .fault_err    (fault_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic l0, input logic l1);
        lane0_done = l0;
        lane1_done = l1;
        step();
        lane0_done = 1'b0;
        lane1_done = 1'b0;
    endtask

    task automatic check_errs(input string tag, input logic p, input logic t, input logic f);
        check({tag, ".protocol_err"}, 32'(protocol_err), 32'(p));
        check({tag, ".timeout_err"},  32'(timeout_err),  32'(t));
        check({tag, ".fault_err"},    32'(fault_err),    32'(f));
    endtask

    initial begin
        reset_n = 1'b0; active = 1'b0; fault = 1'b0;
        lane0_done = 1'b0; lane1_done = 1'b0; clear_err = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;

        // reset then idle
        repeat (10) step();
        check("idle.switch", 32'(switch), 0);
        check("idle.g0", 32'(lane0_grant), 1);
        check("idle.g1", 32'(lane1_grant), 0);
        check("idle.draining", 32'(draining), 0);
        check("idle.swap", 32'(swap_count), 0);
        check_errs("idle", 0, 0, 0);

        // quiet handover lane0 -> lane1: N+1 grant drop, N+3 toggle
        pulse(1'b1, 1'b0);
        check("h1.g0_drop", 32'(lane0_grant), 0);
        check("h1.draining", 32'(draining), 1);
        check("h1.switch0", 32'(switch), 0);
        step();
        check("h1.switch_n2", 32'(switch), 0);
        check("h1.g1_n2", 32'(lane1_grant), 0);
        step();
        check("h1.switch_n3", 32'(switch), 1);
        check("h1.g1_n3", 32'(lane1_grant), 1);
        check("h1.drain_end", 32'(draining), 0);
        check("h1.swap", 32'(swap_count), 1);

        // back to lane 0
        pulse(1'b0, 1'b1);
        check("h2.g1_drop", 32'(lane1_grant), 0);
        step();
        step();
        check("h2.switch", 32'(switch), 0);
        check("h2.g0", 32'(lane0_grant), 1);
        check("h2.swap", 32'(swap_count), 2);

        // busy drain: active for 5 cycles starting with the done cycle
        active = 1'b1;
        pulse(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("busy.hold_switch", 32'(switch), 0);
        end
        active = 1'b0;
        step();
        check("busy.switch_q1", 32'(switch), 0);
        step();
        check("busy.switch", 32'(switch), 1);
        check("busy.swap", 32'(swap_count), 3);
        check_errs("busy", 0, 0, 0);
        pulse(1'b0, 1'b1);
        step();
        step();
        check("busy.back_switch", 32'(switch), 0);
        check("busy.back_swap", 32'(swap_count), 4);

        // drain timeout with TIMEOUT=8
        active = 1'b1;
        pulse(1'b1, 1'b0);
        repeat (8) step();
        check("tmo.before", 32'(timeout_err), 0);
        step();
        check("tmo.set", 32'(timeout_err), 1);
        repeat (11) step();
        check("tmo.hold_switch", 32'(switch), 0);
        check("tmo.still_drain", 32'(draining), 1);
        check("tmo.sticky", 32'(timeout_err), 1);
        active = 1'b0;
        step();
        check("tmo.q1_switch", 32'(switch), 0);
        step();
        check("tmo.toggle", 32'(switch), 1);
        check("tmo.swap", 32'(swap_count), 5);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        check("tmo.cleared", 32'(timeout_err), 0);

        // return to OWN0 for protocol checks
        pulse(1'b0, 1'b1);
        step();
        step();
        check("pr.own0", 32'(switch), 0);
        check("pr.swap", 32'(swap_count), 6);

        pulse(1'b0, 1'b1);
        check("pr.nonowner_err", 32'(protocol_err), 1);
        check("pr.nonowner_g0", 32'(lane0_grant), 1);
        check("pr.nonowner_drain", 32'(draining), 0);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        check("pr.cleared", 32'(protocol_err), 0);

        pulse(1'b1, 1'b1);
        check("pr.both_drain", 32'(draining), 1);
        check("pr.both_g0", 32'(lane0_grant), 0);
        check("pr.both_err", 32'(protocol_err), 1);
        step();
        step();
        check("pr.both_toggle", 32'(switch), 1);
        check("pr.both_swap", 32'(swap_count), 7);

        fault = 1'b1;
        step();
        fault = 1'b0;
        check("flt.set", 32'(fault_err), 1);
        check("flt.switch", 32'(switch), 1);
        check("flt.g1", 32'(lane1_grant), 1);
        fault = 1'b1;
        clear_err = 1'b1;
        step();
        fault = 1'b0;
        check("flt.set_wins", 32'(fault_err), 1);
        step();
        clear_err = 1'b0;
        check("flt.cleared", 32'(fault_err), 0);
        check("flt.proto_cleared", 32'(protocol_err), 0);

        // async reset mid-DRAIN1
        pulse(1'b0, 1'b1);
        check("rst.pre_drain", 32'(draining), 1);
        check("rst.pre_switch", 32'(switch), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst.switch", 32'(switch), 0);
        check("rst.g0", 32'(lane0_grant), 1);
        check("rst.g1", 32'(lane1_grant), 0);
        check("rst.draining", 32'(draining), 0);
        check("rst.swap", 32'(swap_count), 0);
        check_errs("rst", 0, 0, 0);
        step();
        reset_n = 1'b1;
        step();
        check("rst.after_switch", 32'(switch), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/laneswitch_ctrl.md
Name: laneswitch_ctrl

Overview:
Ownership controller that drives the `switch` input of the laneswitch memory mux. Directly upstream of it.
- Passes the single 2-port buffer between lane 0 (producer) and lane 1 (consumer) as a ping-pong token.
- Toggles `switch` only after the buffer has been quiet for a programmable number of cycles.
- Reports protocol violations and drain timeouts as sticky errors.

Parameters:
- QUIET_CYCLES, 2, consecutive cycles with active=0 required before a toggle; legal range >=1.
- TIMEOUT, 1024, drain-cycle limit before timeout_err is raised; 0 disables the timeout.
- CNT_WIDTH, 16, width of swap_count and of the timeout counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- active  input  1  laneswitch active (mem ce0|ce1).
- fault  input  1  laneswitch fault indication.
- lane0_done  input  1  single-cycle pulse: producer finished with the buffer.
- lane1_done  input  1  single-cycle pulse: consumer finished with the buffer.
- clear_err  input  1  clears all sticky error bits.
- switch  output  1  to laneswitch; 0 = lane 0 owns memory, 1 = lane 1 owns memory.
- lane0_grant  output  1  lane 0 may issue memory transactions.
- lane1_grant  output  1  lane 1 may issue memory transactions.
- draining  output  1  controller is in a DRAIN state.
- swap_count  output  CNT_WIDTH  number of completed toggles; wraps modulo 2^CNT_WIDTH.
- protocol_err  output  1  sticky: a done pulse arrived from a lane that did not hold the grant.
- timeout_err  output  1  sticky: a drain exceeded TIMEOUT cycles.
- fault_err  output  1  sticky: fault was observed high.

Behaviour:
- Reset (reset_n=0, asynchronous; takes effect immediately, including mid-drain):
  - state=OWN0, switch=0, lane0_grant=1, lane1_grant=0, draining=0.
  - quiet_cnt=0, tmo_cnt=0, swap_count=0, all error bits 0.
- All outputs are registered; none is driven combinationally from an input.
- States: OWN0, DRAIN0, OWN1, DRAIN1.
- OWN0:
  - switch=0, lane0_grant=1.
  - lane0_done=1 -> next state DRAIN0; lane0_grant=0 and draining=1 in the next cycle.
- DRAIN0:
  - switch stays 0; both grants are 0.
  - Each cycle: active=0 increments quiet_cnt; active=1 resets quiet_cnt to 0.
  - When active=0 and quiet_cnt==QUIET_CYCLES-1, the next cycle has:
    - state=OWN1, switch=1, lane1_grant=1, draining=0;
    - swap_count+1, quiet_cnt=0, tmo_cnt=0.
- OWN1 and DRAIN1 mirror OWN0 and DRAIN0 with the lanes exchanged; the toggle returns switch to 0 and raises lane0_grant.
- Latency: with active=0 throughout, a done pulse at cycle N gives switch toggled and the new grant high at cycle N+1+QUIET_CYCLES (N+3 at default).
- Timeout:
  - tmo_cnt increments every DRAIN cycle and saturates.
  - If TIMEOUT!=0 and tmo_cnt reaches TIMEOUT, timeout_err is set.
  - The controller keeps draining and never forces a toggle while active is not quiet.
- Protocol errors:
  - A done pulse from the non-owning lane, in any state, is ignored and sets protocol_err.
  - A done pulse from the owning lane during DRAIN (duplicate) is ignored and sets protocol_err.
  - Both done pulses in the same cycle in OWN0: lane0_done is honoured and protocol_err is set. OWN1 mirrors this.
- fault=1 in any cycle sets fault_err. It does not alter the state.
- clear_err=1 clears all sticky bits next cycle. If a set condition occurs in the same cycle, set wins.
- swap_count wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- Invariants, checked by assertion:
  - lane0_grant & lane1_grant is never 1.
  - switch changes only on a DRAIN->OWN transition.
  - active=1 is never observed in the cycle switch toggles.

Test Plan:
- Reset then idle 10 cycles -> switch=0, lane0_grant=1, lane1_grant=0, swap_count=0, all errors 0.
- lane0_done at cycle 5, active=0 -> lane0_grant=0 at 6; switch=1 and lane1_grant=1 at 8; swap_count=1.
- lane0_done at 5, active=1 for cycles 5..9 then 0 -> switch=1 at 12; no error. Then lane1_done -> switch back to 0 after 3 cycles; swap_count=2.
- TIMEOUT=8, lane0_done then active held 1 for 20 cycles -> timeout_err=1 at ~cycle 9 after entry, switch stays 0. Drop active -> toggle 2 cycles later. clear_err -> timeout_err=0.
- In OWN0, pulse lane1_done -> protocol_err=1, state unchanged. Pulse lane0_done and lane1_done together -> DRAIN0 entered, protocol_err=1. fault=1 for one cycle -> fault_err=1.
- Assert reset_n=0 mid-DRAIN1 with switch=1 -> switch=0, lane0_grant=1, swap_count=0 immediately, without waiting for a clock edge.
